// File: rtl/seq_input_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_input_capture_pkg                                                |
// | Shared state encoding, defaults and button-pattern helpers.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_input_capture_pkg;

    localparam int N_BTN_DEF = 8;
    localparam int DEPTH_DEF = 16;
    // Helpers take a fixed-width vector; callers zero-extend their pattern.
    localparam int MAX_BTN   = 64;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] S_WAIT_REL = 3'd1;
    localparam logic [STATE_W-1:0] S_ARMED    = 3'd2;
    localparam logic [STATE_W-1:0] S_HELD     = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE     = 3'd4;

    function automatic logic [5:0] onehot_to_idx(input logic [MAX_BTN-1:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_BTN; i++) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    // True when more than one bit is set.
    function automatic logic multi_hot(input logic [MAX_BTN-1:0] v);
        return (v & (v - 64'd1)) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_input_capture_btn_sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_sync_debounce                                                    |
// | Two-flop synchroniser plus stable-pattern counter for a button bank. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module btn_sync_debounce #(
    parameter int N_BTN   = 8,
    parameter int DEB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] sbtn,
    output logic [N_BTN-1:0] pattern,
    output logic             stable
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);

    logic [N_BTN-1:0] r_meta;
    logic [N_BTN-1:0] r_sync;
    logic [N_BTN-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt;

    // The reported pattern is the delayed copy the counter has been tracking,
    // so a fresh change never borrows the old pattern's saturated count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_meta <= btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (r_sync != r_prev)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sbtn    = r_sync;
    assign pattern = r_prev;
    assign stable  = (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/seq_input_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_input_capture                                                    |
// | Debounced single-button press capture into an addressable buffer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_input_capture
    import seq_input_capture_pkg::*;
#(
    parameter int N_BTN   = N_BTN_DEF,
    parameter int IDX_W   = $clog2(N_BTN),
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LEN_W   = $clog2(DEPTH + 1),
    parameter int DEB_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [LEN_W-1:0]         target_len,
    input  logic [N_BTN-1:0]         btn,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [IDX_W-1:0]         rd_data,
    output logic [LEN_W-1:0]         count,
    output logic                     press_valid,
    output logic [IDX_W-1:0]         press_idx,
    output logic                     multi_err,
    output logic                     done
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [N_BTN-1:0]   w_sbtn;
    logic [N_BTN-1:0]   w_pattern;
    logic               w_stable;
    logic [LEN_W-1:0]   w_tgt;
    logic               w_released;

    logic [STATE_W-1:0] r_state;
    logic [LEN_W-1:0]   r_tgt;
    logic [LEN_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   r_press_idx;
    logic               r_rej;
    logic               r_press_valid;
    logic               r_multi_err;
    logic [IDX_W-1:0]   r_buf [DEPTH];

    btn_sync_debounce #(
        .N_BTN   (N_BTN),
        .DEB_CYC (DEB_CYC)
    ) u_sync_deb (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .sbtn    (w_sbtn),
        .pattern (w_pattern),
        .stable  (w_stable)
    );

    always_comb begin
        w_tgt = target_len;
        if (target_len == '0)
            w_tgt = LEN_W'(1);
        else if (target_len > LEN_W'(DEPTH))
            w_tgt = LEN_W'(DEPTH);
    end

    assign w_released = w_stable && (w_pattern == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tgt         <= LEN_W'(1);
            r_count       <= '0;
            r_cur         <= '0;
            r_press_idx   <= '0;
            r_rej         <= 1'b0;
            r_press_valid <= 1'b0;
            r_multi_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_press_valid <= 1'b0;
            r_multi_err   <= 1'b0;
            if (clear) begin
                r_count <= '0;
                r_rej   <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_tgt   <= w_tgt;
                            // Resuming with a smaller target than already stored finishes at once.
                            r_state <= (r_count >= w_tgt) ? S_DONE : S_WAIT_REL;
                        end
                    end
                    S_WAIT_REL: begin
                        if (!enable)
                            r_state <= S_IDLE;
                        else if (w_released)
                            r_state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (!enable) begin
                            r_state <= S_IDLE;
                        end else if (w_stable && (w_pattern != '0)) begin
                            r_rej   <= multi_hot(MAX_BTN'(w_pattern));
                            r_cur   <= IDX_W'(onehot_to_idx(MAX_BTN'(w_pattern)));
                            r_state <= S_HELD;
                        end
                    end
                    S_HELD: begin
                        if (!enable) begin
                            r_rej   <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_released) begin
                            r_rej <= 1'b0;
                            if (r_rej) begin
                                r_multi_err <= 1'b1;
                                r_state     <= S_ARMED;
                            end else begin
                                r_buf[r_count[ADDR_W-1:0]] <= r_cur;
                                r_count       <= r_count + LEN_W'(1);
                                r_press_valid <= 1'b1;
                                r_press_idx   <= r_cur;
                                r_state       <= (r_count + LEN_W'(1) == r_tgt) ? S_DONE : S_ARMED;
                            end
                        end else if (multi_hot(MAX_BTN'(w_sbtn))) begin
                            r_rej <= 1'b1;
                        end
                    end
                    S_DONE: begin
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (LEN_W'(rd_addr) < r_count)
            rd_data = r_buf[rd_addr];
    end

    assign count       = r_count;
    assign press_valid = r_press_valid;
    assign press_idx   = r_press_idx;
    assign multi_err   = r_multi_err;
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire
